// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and its flags register.
package alu_pkg;

  // Operation select, taken from instruction bits 6:3.
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADC   = 4'd1,
    OP_SUB   = 4'd2,
    OP_SBC   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_INC   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_SAR   = 4'd10,
    OP_RCL   = 4'd11,
    OP_RCR   = 4'd12,
    OP_PASSA = 4'd13,
    OP_PASSB = 4'd14,
    OP_ZERO  = 4'd15
  } op_e;

  // Bit positions inside the 4-bit flags word.
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_W = 4;

endpackage

// File: rtl/alu_flags_if.sv
// Control-unit to ALU signal bundle: operands, op select, enables and flags readback.
interface alu_flags_if;
  import alu_pkg::*;

  logic [7:0]        a;
  logic [7:0]        b;
  logic [3:0]        op;
  logic              invert;
  logic              n_alu_oe;
  logic              n_flags_we;
  logic [FLAG_W-1:0] flags;

  modport master (
    output a, b, op, invert, n_alu_oe, n_flags_we,
    input  flags
  );

  modport slave (
    input  a, b, op, invert, n_alu_oe, n_flags_we,
    output flags
  );

endinterface

// File: rtl/flag_register.sv
// 4-bit flags register: async active-low clear, synchronous active-low parallel load.
module flag_register
  import alu_pkg::*;
(
  input  logic              n_clk,
  input  logic              n_rst,
  input  logic              n_load,
  input  logic [FLAG_W-1:0] d,
  output logic [FLAG_W-1:0] q
);

  logic [FLAG_W-1:0] q_q;

  // Clear wins over load; otherwise load on rising edge when n_load is low.
  always_ff @(posedge n_clk or negedge n_rst) begin
    if (!n_rst) begin
      q_q <= '0;
    end else if (!n_load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/alu_flags.sv
// 8-bit ALU with tri-state result and latched Z/C/S/O flags (execute stage).
module alu_flags
  import alu_pkg::*;
(
  input  logic       n_clk,
  input  logic       n_rst,
  alu_flags_if.slave bus,
  output wire  [7:0] result
);

  op_e               op;
  logic              c_in;
  logic [7:0]        add_b;
  logic              add_cin;
  logic [8:0]        add_sum;
  logic              add_v;
  logic [7:0]        r;
  logic              c;
  logic              v;
  logic [7:0]        y;
  logic [FLAG_W-1:0] flags_d;

  assign op   = op_e'(bus.op);
  // Stored carry; the register breaks the loop back into the adder and rotates.
  assign c_in = bus.flags[FLAG_C];

  // Shared adder operand/carry selection for ADD/ADC/SUB/SBC/INC.
  always_comb begin
    add_b   = bus.b;
    add_cin = 1'b0;
    case (op)
      OP_ADC: add_cin = c_in;
      OP_SUB: begin
        add_b   = ~bus.b;
        add_cin = 1'b1;
      end
      OP_SBC: begin
        add_b   = ~bus.b;
        add_cin = c_in;
      end
      OP_INC: begin
        add_b   = 8'h00;
        add_cin = 1'b1;
      end
      default: ;
    endcase
    add_sum = {1'b0, bus.a} + {1'b0, add_b} + {8'h00, add_cin};
    // Signed overflow: like-signed addends giving an opposite-signed sum.
    add_v   = (bus.a[7] == add_b[7]) && (add_sum[7] != bus.a[7]);
  end

  // Raw result, carry and overflow per operation.
  always_comb begin
    r = 8'h00;
    c = 1'b0;
    v = 1'b0;
    unique case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC: begin
        r = add_sum[7:0];
        c = add_sum[8];
        v = add_v;
      end
      OP_AND:   r = bus.a & bus.b;
      OP_OR:    r = bus.a | bus.b;
      OP_XOR:   r = bus.a ^ bus.b;
      OP_SHL: begin
        r = {bus.a[6:0], 1'b0};
        c = bus.a[7];
      end
      OP_SHR: begin
        r = {1'b0, bus.a[7:1]};
        c = bus.a[0];
      end
      OP_SAR: begin
        r = {bus.a[7], bus.a[7:1]};
        c = bus.a[0];
      end
      OP_RCL: begin
        r = {bus.a[6:0], c_in};
        c = bus.a[7];
      end
      OP_RCR: begin
        r = {c_in, bus.a[7:1]};
        c = bus.a[0];
      end
      OP_PASSA: r = bus.a;
      OP_PASSB: r = bus.b;
      OP_ZERO:  r = 8'h00;
    endcase
  end

  // Final value and next flags; invert touches only Z and S, never C or O.
  always_comb begin
    y               = bus.invert ? ~r : r;
    flags_d         = '0;
    flags_d[FLAG_Z] = (y == 8'h00);
    flags_d[FLAG_C] = c;
    flags_d[FLAG_S] = y[7];
    flags_d[FLAG_O] = v;
  end

  assign result = bus.n_alu_oe ? 8'bzzzz_zzzz : y;

  flag_register u_flag_register (
    .n_clk  (n_clk),
    .n_rst  (n_rst),
    .n_load (bus.n_flags_we),
    .d      (flags_d),
    .q      (bus.flags)
  );

endmodule

// File: tb/tb_alu_flags.sv
// Directed scoreboard bench for alu_flags; result bus has a pull-up so high-Z reads as 8'hFF.
module tb_alu_flags;
  import alu_pkg::*;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic [3:0] flg;
  } exp_t;

  exp_t       sb[$];
  logic       n_clk = 1'b0;
  logic       n_rst = 1'b0;
  tri1  [7:0] result_w;
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] model_flags = 4'h0;

  alu_flags_if bus ();

  alu_flags dut (
    .n_clk  (n_clk),
    .n_rst  (n_rst),
    .bus    (bus),
    .result (result_w)
  );

  always #5 n_clk = ~n_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Independent reference: integer arithmetic instead of a shared adder.
  function automatic exp_t predict(input string tag, input logic [3:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic inv, input logic oe_n,
                                   input logic we_n, input logic [3:0] cur);
    exp_t       e;
    int         ua, ub, sa, sb2, s, ss, ci;
    logic [7:0] rr, yy;
    logic       cc, vv;
    ua = a; ub = b; sa = $signed(a); sb2 = $signed(b); ci = cur[1];
    rr = 8'h00; cc = 1'b0; vv = 1'b0; s = 0; ss = 0;
    case (op)
      4'd0:  begin s = ua + ub; ss = sa + sb2; cc = s > 255; end
      4'd1:  begin s = ua + ub + ci; ss = sa + sb2 + ci; cc = s > 255; end
      4'd2:  begin s = ua - ub; ss = sa - sb2; cc = s >= 0; end
      4'd3:  begin s = ua - ub - (1 - ci); ss = sa - sb2 - (1 - ci); cc = s >= 0; end
      4'd7:  begin s = ua + 1; ss = sa + 1; cc = s > 255; end
      default: ;
    endcase
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd7: begin
        rr = 8'(s);
        vv = (ss > 127) || (ss < -128);
      end
      4'd4:  rr = a & b;
      4'd5:  rr = a | b;
      4'd6:  rr = a ^ b;
      4'd8:  begin rr = 8'(ua * 2); cc = ua >= 128; end
      4'd9:  begin rr = 8'(ua / 2); cc = ua % 2 == 1; end
      4'd10: begin rr = 8'(sa >>> 1); cc = ua % 2 == 1; end
      4'd11: begin rr = 8'(ua * 2 + ci); cc = ua >= 128; end
      4'd12: begin rr = 8'(ua / 2 + ci * 128); cc = ua % 2 == 1; end
      4'd13: rr = a;
      4'd14: rr = b;
      default: rr = 8'h00;
    endcase
    yy    = inv ? ~rr : rr;
    e.tag = tag;
    e.res = oe_n ? 8'hFF : yy;
    e.flg = we_n ? cur : {vv, yy[7], cc, (yy == 8'h00)};
    return e;
  endfunction

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: result got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: flags got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic inv, input logic oe_n, input logic we_n);
    exp_t e;
    @(negedge n_clk);
    bus.op = op; bus.a = a; bus.b = b; bus.invert = inv;
    bus.n_alu_oe = oe_n; bus.n_flags_we = we_n;
    sb.push_back(predict(tag, op, a, b, inv, oe_n, we_n, model_flags));
    #1;
    e = sb.pop_front();
    check8({e.tag, "_res"}, result_w, e.res);
    model_flags = e.flg;
    @(posedge n_clk);
    #1;
    check4({e.tag, "_flg"}, bus.flags, model_flags);
  endtask

  initial begin
    bus.a = 8'h00; bus.b = 8'h00; bus.op = 4'd0; bus.invert = 1'b0;
    bus.n_alu_oe = 1'b0; bus.n_flags_we = 1'b0;
    #1;
    check4("por_flags", bus.flags, 4'h0);
    @(negedge n_clk);
    n_rst = 1'b1;

    step("add_ovf",  OP_ADD,   8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    step("add_cy",   OP_ADD,   8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    step("adc",      OP_ADC,   8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    step("sub_eq",   OP_SUB,   8'h05, 8'h05, 1'b0, 1'b0, 1'b0);
    step("and_zero", OP_AND,   8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0);
    step("sbc_c0",   OP_SBC,   8'h05, 8'h01, 1'b0, 1'b0, 1'b0);
    step("rcr_c1",   OP_RCR,   8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    step("xor_inv",  OP_XOR,   8'hAA, 8'hAA, 1'b1, 1'b0, 1'b0);
    step("sub_brw",  OP_SUB,   8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    step("sbc_ovf",  OP_SBC,   8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
    step("inc_ovf",  OP_INC,   8'h7F, 8'h00, 1'b0, 1'b0, 1'b0);
    step("inc_wrap", OP_INC,   8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    step("rcl_c1",   OP_RCL,   8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
    step("shl",      OP_SHL,   8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    step("sar",      OP_SAR,   8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    step("shr",      OP_SHR,   8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    step("or_inv",   OP_OR,    8'h0F, 8'h30, 1'b1, 1'b0, 1'b0);
    step("passa",    OP_PASSA, 8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0);
    step("passb",    OP_PASSB, 8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0);
    step("zero_inv", OP_ZERO,  8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    // Output disabled: bus floats to the pull-up, flags still load.
    step("oe_off",   OP_ZERO,  8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
    // Load disabled: flags hold while op and operands change.
    step("hold1",    OP_ADD,   8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    step("hold2",    OP_SUB,   8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
    step("hold3",    OP_SHL,   8'h80, 8'h00, 1'b1, 1'b0, 1'b1);

    // Load C=1,Z=1,O=1 then clear asynchronously mid-cycle.
    step("pre_rst",  OP_ADD,   8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    @(negedge n_clk);
    #2;
    n_rst = 1'b0;
    #1;
    model_flags = 4'h0;
    check4("async_clr", bus.flags, model_flags);
    bus.op = OP_ADD; bus.a = 8'hFF; bus.b = 8'h01; bus.n_flags_we = 1'b0;
    @(posedge n_clk);
    #1;
    check4("rst_over_load", bus.flags, model_flags);
    @(negedge n_clk);
    n_rst = 1'b1;
    step("post_rst", OP_ADD,   8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
